timer_counter_core: RTL

// Counter datapath driven by the AXI4-Lite timer register block. It consumes one timer's

---
 rtl/timer_counter_core.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/timer_counter_core.sv
// ---------------------------------------------------------------------------
// timer_counter_core
//
// Counter datapath for one timer channel. Takes the timer's control fields
// from the register block, counts on either an internal prescaled tick or a
// synchronised external tick, and returns the live count for readback along
// with match/overflow pulses and a sticky interrupt.
//
// Parameters
//   PRESCALE_p      internal tick period in clk cycles (>= 1)
//   PRESC_BW_p      prescaler counter width (PRESCALE_p < 2**PRESC_BW_p)
//
// Ports
//   clk              clock, all logic on its rising edge
//   rst              synchronous active-high reset
//   i_en             counter enable
//   i_reload         1 = auto-reload on match, 0 = one-shot
//   i_count_up       1 = increment, 0 = decrement
//   i_src            tick source: 0 = prescaler, 1 = external tick edge
//   i_load_value     start / reload value
//   i_compare_value  match value
//   i_ext_tick       external or cascade tick, may be asynchronous
//   i_irq_clr        single-cycle pulse clearing o_irq
//   o_value          current count
//   o_match          single-cycle pulse on compare match
//   o_ovf            single-cycle pulse on wrap-around
//   o_irq            sticky interrupt, set by a match
//   o_running        high while the counter is in RUN
// ---------------------------------------------------------------------------
module timer_counter_core #(
    parameter int PRESCALE_p = 1,
    parameter int PRESC_BW_p = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_reload,
    input  logic        i_count_up,
    input  logic        i_src,
    input  logic [31:0] i_load_value,
    input  logic [31:0] i_compare_value,
    input  logic        i_ext_tick,
    input  logic        i_irq_clr,
    output logic [31:0] o_value,
    output logic        o_match,
    output logic        o_ovf,
    output logic        o_irq,
    output logic        o_running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [PRESC_BW_p-1:0] PrescMax = PRESC_BW_p'(PRESCALE_p - 1);

    state_e                state_q;
    logic [31:0]           value_q;
    logic [PRESC_BW_p-1:0] prescCnt_q;
    logic                  enPrev_q;
    logic                  srcPrev_q;
    logic                  syncMeta_q;
    logic                  syncOut_q;
    logic                  syncEdge_q;
    logic                  match_q;
    logic                  ovf_q;
    logic                  irq_q;
    logic                  running_q;

    logic                  tickPresc;
    logic                  tickExt;
    logic                  tick;
    logic                  matchEvent;
    logic [31:0]           stepValue_d;
    logic                  stepWrap_d;

    // The tick source is taken from the registered select, so a change of
    // i_src only steers ticks from the following cycle on.
    assign tickPresc  = (prescCnt_q == PrescMax);
    assign tickExt    = syncOut_q & ~syncEdge_q;
    assign tick       = srcPrev_q ? tickExt : tickPresc;

    // A match is only honoured while enabled and running; disabling wins.
    assign matchEvent = i_en && (state_q == RUN) && tick &&
                        (value_q == i_compare_value);

    // Stepped value and wrap detection, evaluated on the pre-step count.
    always_comb begin
        stepValue_d = value_q;
        stepWrap_d  = 1'b0;
        if (i_count_up) begin
            stepValue_d = value_q + 32'd1;
            stepWrap_d  = (value_q == 32'hFFFF_FFFF);
        end else begin
            stepValue_d = value_q - 32'd1;
            stepWrap_d  = (value_q == 32'h0000_0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            value_q    <= '0;
            prescCnt_q <= '0;
            enPrev_q   <= 1'b0;
            srcPrev_q  <= 1'b0;
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
            syncEdge_q <= 1'b0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            enPrev_q   <= i_en;
            srcPrev_q  <= i_src;
            syncMeta_q <= i_ext_tick;
            syncOut_q  <= syncMeta_q;
            syncEdge_q <= syncOut_q;

            // Pulses and the prescaler default to zero; only the branches
            // below that need them keep them alive.
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            prescCnt_q <= '0;

            if (!i_en) begin
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!enPrev_q) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                            value_q   <= i_load_value;
                        end
                    end
                    RUN: begin
                        // The prescaler idles at zero on the external source
                        // and restarts whenever the source select moves.
                        if (!srcPrev_q && !tickPresc && (i_src == srcPrev_q)) begin
                            prescCnt_q <= prescCnt_q + PRESC_BW_p'(1);
                        end
                        if (tick) begin
                            if (matchEvent) begin
                                match_q <= 1'b1;
                                if (i_reload) begin
                                    value_q <= i_load_value;
                                end else begin
                                    state_q   <= DONE;
                                    running_q <= 1'b0;
                                end
                            end else begin
                                value_q <= stepValue_d;
                                ovf_q   <= stepWrap_d;
                            end
                        end
                    end
                    DONE: begin
                        running_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end

            // A new match beats a simultaneous clear.
            if (matchEvent) begin
                irq_q <= 1'b1;
            end else if (i_irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign o_value   = value_q;
    assign o_match   = match_q;
    assign o_ovf     = ovf_q;
    assign o_irq     = irq_q;
    assign o_running = running_q;

endmodule
